// File: rtl/mux_tree_pipe_if.sv
// Channel bank / result bundle for mux_tree_pipe.
// scan exists only when MUX_AUTOSCAN_EN is defined.
interface mux_tree_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic [WIDTH*(2**SEL_W)-1:0] in;
  logic [SEL_W-1:0]            sel;
  logic                        in_valid;
`ifdef MUX_AUTOSCAN_EN
  logic                        scan;
`endif
  logic [WIDTH-1:0]            out;
  logic                        out_valid;
  logic [SEL_W-1:0]            out_sel;

`ifdef MUX_AUTOSCAN_EN
  modport master (
    output in, sel, in_valid, scan,
    input  out, out_valid, out_sel
  );
  modport slave (
    input  in, sel, in_valid, scan,
    output out, out_valid, out_sel
  );
`else
  modport master (
    output in, sel, in_valid,
    input  out, out_valid, out_sel
  );
  modport slave (
    input  in, sel, in_valid,
    output out, out_valid, out_sel
  );
`endif
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree of registered 4:1 stages, latency SEL_W/2.
// Optional auto-scan select counter under MUX_AUTOSCAN_EN.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input logic           clk,
  input logic           rst,
  mux_tree_pipe_if.slave bus
);
  localparam int N = 2**SEL_W;
  localparam int L = SEL_W / 2;

  logic [SEL_W-1:0] esel;

`ifdef MUX_AUTOSCAN_EN
  logic [SEL_W-1:0] scnt_q, scnt_d;

  always_comb begin
    scnt_d = scnt_q;
    if (bus.scan && bus.in_valid)
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) scnt_q <= '0;
    else     scnt_q <= scnt_d;
  end

  assign esel = bus.scan ? scnt_q : bus.sel;
`else
  assign esel = bus.sel;
`endif

  for (genvar s = 0; s < L; s++) begin : g_st
    localparam int M = N >> (2 * (s + 1));

    logic [4*M*WIDTH-1:0] src;
    logic [SEL_W-1:0]     src_sel;
    logic                 src_v;
    logic [1:0]           idx;
    logic [M*WIDTH-1:0]   d_d;
    logic [M*WIDTH-1:0]   d_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 v_q;

    if (s == 0) begin : g_src
      assign src     = bus.in;
      assign src_sel = esel;
      assign src_v   = bus.in_valid;
    end else begin : g_src
      assign src     = g_st[s-1].d_q;
      assign src_sel = g_st[s-1].sel_q;
      assign src_v   = g_st[s-1].v_q;
    end

    assign idx = src_sel[2*s +: 2];

    always_comb begin
      d_d = '0;
      for (int j = 0; j < M; j++)
        d_d[j*WIDTH +: WIDTH] =
          src[(4*j + int'(idx))*WIDTH +: WIDTH];
    end

    if (s == L - 1) begin : g_last
      // final stage holds its result across bubbles
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q   <= '0;
          sel_q <= '0;
          v_q   <= 1'b0;
        end else begin
          v_q <= src_v;
          if (src_v) begin
            d_q   <= d_d;
            sel_q <= src_sel;
          end
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q   <= '0;
          sel_q <= '0;
          v_q   <= 1'b0;
        end else begin
          d_q   <= d_d;
          sel_q <= src_sel;
          v_q   <= src_v;
        end
      end
    end
  end

  assign bus.out       = g_st[L-1].d_q;
  assign bus.out_sel   = g_st[L-1].sel_q;
  assign bus.out_valid = g_st[L-1].v_q;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: queue model checked every cycle plus literal checks.
// Scan test runs only when MUX_AUTOSCAN_EN is defined.
module tb_mux_tree_pipe;
  localparam int WIDTH = 8;
  localparam int SEL_W = 4;
  localparam int N     = 2**SEL_W;
  localparam int L     = SEL_W / 2;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  mux_tree_pipe_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // model: a pure delay line of what each edge selected
  item_t            q[$];
  logic [WIDTH-1:0] m_out = '0;
  logic [SEL_W-1:0] m_sel = '0;
  logic             m_v = 1'b0;
  logic [SEL_W-1:0] m_scnt = '0;
  bit               started = 0;

  always @(posedge clk) begin
    item_t it;
    logic [SEL_W-1:0] es;
    started = 1;
    es = bus.sel;
`ifdef MUX_AUTOSCAN_EN
    if (!rst && bus.scan) es = m_scnt;
    if (rst) m_scnt = '0;
    else if (bus.scan && bus.in_valid) m_scnt = m_scnt + 1'b1;
`endif
    if (rst) begin
      q.delete();
      m_out = '0;
      m_sel = '0;
      m_v   = 1'b0;
    end else begin
      it.v = bus.in_valid;
      it.s = es;
      it.d = bus.in[int'(es)*WIDTH +: WIDTH];
      q.push_back(it);
      m_v = 1'b0;
      if (q.size() > L - 1) begin
        it  = q.pop_front();
        m_v = it.v;
        if (it.v) begin
          m_out = it.d;
          m_sel = it.s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid", 32'(bus.out_valid), 32'(m_v));
      chk("model_out",   32'(bus.out),       32'(m_out));
      chk("model_sel",   32'(bus.out_sel),   32'(m_sel));
    end
  end

  task automatic cyc(input logic r, input logic v,
                     input logic [SEL_W-1:0] s);
    rst          = r;
    bus.in_valid = v;
    bus.sel      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic v,
                     input logic [WIDTH-1:0] d,
                     input logic [SEL_W-1:0] s);
    chk({name, "_v"}, 32'(bus.out_valid), 32'(v));
    chk({name, "_d"}, 32'(bus.out),       32'(d));
    chk({name, "_s"}, 32'(bus.out_sel),   32'(s));
  endtask

  task automatic ramp();
    for (int k = 0; k < N; k++)
      bus.in[k*WIDTH +: WIDTH] = WIDTH'(8'h10 + k);
  endtask

  initial begin
    ramp();
    bus.in_valid = 1'b1;
    bus.sel      = 4'd5;
`ifdef MUX_AUTOSCAN_EN
    bus.scan = 1'b0;
`endif
    // reset held with valid traffic
    cyc(1, 1, 5);  lit("rst0", 0, 8'h00, 0);
    cyc(1, 1, 5);  lit("rst1", 0, 8'h00, 0);
    cyc(0, 0, 5);  lit("rst2", 0, 8'h00, 0);
    cyc(0, 0, 0);  lit("rst3", 0, 8'h00, 0);

    // single input
    cyc(0, 1, 5);
    cyc(0, 0, 0);  lit("one",  1, 8'h15, 5);
    cyc(0, 0, 0);  lit("hold", 0, 8'h15, 5);

    // back to back
    cyc(0, 1, 0);
    cyc(0, 1, 15); lit("b2b0", 1, 8'h10, 0);
    cyc(0, 1, 7);  lit("b2b1", 1, 8'h1F, 15);
    cyc(0, 0, 0);  lit("b2b2", 1, 8'h17, 7);
    cyc(0, 0, 0);  lit("b2b3", 0, 8'h17, 7);

    // bubble
    cyc(0, 1, 3);
    cyc(0, 0, 9);  lit("bub0", 1, 8'h13, 3);
    cyc(0, 1, 9);  lit("bub1", 0, 8'h13, 3);
    cyc(0, 0, 0);  lit("bub2", 1, 8'h19, 9);

    // reset with traffic in flight
    cyc(0, 1, 2);
    cyc(0, 1, 3);
    cyc(1, 0, 0);  lit("fl0", 0, 8'h00, 0);
    cyc(0, 0, 0);  lit("fl1", 0, 8'h00, 0);
    cyc(0, 1, 4);  lit("fl2", 0, 8'h00, 0);
    cyc(0, 0, 0);  lit("fl3", 1, 8'h14, 4);

    // varied channel data, model-checked
    for (int k = 0; k < N; k++)
      bus.in[k*WIDTH +: WIDTH] = WIDTH'(8'hA5 ^ (k * 37));
    for (int i = 0; i < 40; i++)
      cyc(0, 1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, N-1)));
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    ramp();

`ifdef MUX_AUTOSCAN_EN
    cyc(1, 0, 0);
    bus.scan = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cyc(0, (i < 18), 4'd9);
      if (i >= 1) begin
        chk("scan_sel", 32'(bus.out_sel), 32'((i - 1) % N));
        chk("scan_out", 32'(bus.out), 32'(8'h10 + ((i - 1) % N)));
      end
    end
    bus.scan = 1'b0;
    cyc(0, 1, 6);
    cyc(0, 0, 0);  lit("unscan", 1, 8'h16, 6);
`endif

    cyc(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
